// File: rtl/udar_pkg.sv
// Shared codes, enums and helpers for the UDAR command decoder.
// Optional saturation of servo bytes is built with UDAR_CMD_CLAMP_EN.
package udar_pkg;

  localparam logic [7:0] FC_INIT  = 8'h00;
  localparam logic [7:0] FC_SERVO = 8'h03;
  localparam logic [7:0] FC_TRIG  = 8'h0C;

  localparam logic [7:0] ACK_INIT  = 8'hAA;
  localparam logic [7:0] ACK_SERVO = 8'hAB;
  localparam logic [7:0] ACK_TRIG  = 8'hAE;

  localparam logic [7:0] SERVO_RST = 8'd150;

  typedef enum logic [1:0] {
    CMD_INIT  = 2'd0,
    CMD_SERVO = 2'd1,
    CMD_TRIG  = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GET_X = 2'd1,
    ST_GET_Y = 2'd2
  } state_e;

  function automatic logic [7:0] pos_sat(
    input logic [7:0] b,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (b < lo) return lo;
    if (b > hi) return hi;
    return b;
  endfunction

endpackage

// File: rtl/udar_byte_timer.sv
// Inter-byte timeout counter; expire never fires in a clear cycle.
module udar_byte_timer #(
  parameter int TO_CYCLES  = 50000,
  parameter int TO_CNT_LEN = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TO_CNT_LEN-1:0] CNT_LAST =
    TO_CNT_LEN'(TO_CYCLES - 1);

  logic [TO_CNT_LEN-1:0] cnt_q;
  logic [TO_CNT_LEN-1:0] cnt_d;

  assign expire = run && !clear && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !run || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/udar_cmd_dec.sv
// Serial frame decoder feeding a single-entry command register.
// Build with UDAR_CMD_CLAMP_EN to saturate X/Y to [POS_MIN, POS_MAX].
module udar_cmd_dec
  import udar_pkg::*;
#(
  parameter int TO_CYCLES  = 50000,
  parameter int TO_CNT_LEN = 16,
  parameter int POS_MIN    = 50,
  parameter int POS_MAX    = 250
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_type,
  output logic [7:0] servo_x,
  output logic [7:0] servo_y,
  output logic       err_unknown,
  output logic       err_timeout,
  output logic       err_overrun
);

`ifdef UDAR_CMD_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] x_buf_q, x_buf_d;
  logic       cmd_valid_q, cmd_valid_d;
  cmd_e       cmd_type_q, cmd_type_d;
  logic [7:0] servo_x_q, servo_x_d;
  logic [7:0] servo_y_q, servo_y_d;
  logic       unk_q, unk_d;
  logic       tmo_q, tmo_d;
  logic       ovr_q, ovr_d;

  logic       expire;
  logic       done;
  logic       load;
  cmd_e       new_type;
  logic [7:0] pos_in;

  assign pos_in = CLAMP_EN
    ? pos_sat(rx_data, 8'(POS_MIN), 8'(POS_MAX))
    : rx_data;

  udar_byte_timer #(
    .TO_CYCLES (TO_CYCLES),
    .TO_CNT_LEN(TO_CNT_LEN)
  ) u_timer (
    .clk   (clk),
    .rst_i (rst_i),
    .clear (rx_done),
    .run   (state_q != ST_IDLE),
    .expire(expire)
  );

  always_comb begin
    state_d  = state_q;
    x_buf_d  = x_buf_q;
    done     = 1'b0;
    new_type = CMD_INIT;
    unk_d    = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_done) begin
        unique case (1'b1)
          (rx_data == FC_INIT):  done = 1'b1;
          (rx_data == FC_TRIG): begin
            done     = 1'b1;
            new_type = CMD_TRIG;
          end
          (rx_data == FC_SERVO): state_d = ST_GET_X;
          default:               unk_d = 1'b1;
        endcase
      end
      ST_GET_X: if (rx_done) begin
        x_buf_d = pos_in;
        state_d = ST_GET_Y;
      end else if (expire) begin
        state_d = ST_IDLE;
        tmo_d   = 1'b1;
      end
      ST_GET_Y: if (rx_done) begin
        done     = 1'b1;
        new_type = CMD_SERVO;
        state_d  = ST_IDLE;
      end else if (expire) begin
        state_d = ST_IDLE;
        tmo_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed command only lands if the holding slot is free or draining.
  assign load = done && (!cmd_valid_q || cmd_ready);

  always_comb begin
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    cmd_type_d  = cmd_type_q;
    servo_x_d   = servo_x_q;
    servo_y_d   = servo_y_q;
    ovr_d       = done && !load;
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_type_d  = new_type;
      if (new_type == CMD_SERVO) begin
        servo_x_d = x_buf_q;
        servo_y_d = pos_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      x_buf_q     <= SERVO_RST;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_INIT;
      servo_x_q   <= SERVO_RST;
      servo_y_q   <= SERVO_RST;
      unk_q       <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_buf_q     <= x_buf_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      servo_x_q   <= servo_x_d;
      servo_y_q   <= servo_y_d;
      unk_q       <= unk_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign servo_x     = servo_x_q;
  assign servo_y     = servo_y_q;
  assign err_unknown = unk_q;
  assign err_timeout = tmo_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_udar_cmd_dec.sv
// Directed bench for udar_cmd_dec: vector table plus corner sequences.
// Clamp expectations follow UDAR_CMD_CLAMP_EN.
module tb_udar_cmd_dec;

  localparam int TO = 20;

`ifdef UDAR_CMD_CLAMP_EN
  localparam logic [7:0] CX = 8'd50;
  localparam logic [7:0] CY = 8'd250;
`else
  localparam logic [7:0] CX = 8'd5;
  localparam logic [7:0] CY = 8'd255;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] servo_x;
  logic [7:0] servo_y;
  logic       err_unknown;
  logic       err_timeout;
  logic       err_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  udar_cmd_dec #(
    .TO_CYCLES (TO),
    .TO_CNT_LEN(8)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .servo_x    (servo_x),
    .servo_y    (servo_y),
    .err_unknown(err_unknown),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [1:0] et;
    logic [7:0] ex;
    logic [7:0] ey;
    logic       eu;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Called at a negedge; byte is sampled at the next posedge.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic seen;
    rst_i     = 1'b1;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    cmd_ready = 1'b1;

    v[0]  = '{8'h00, 1'b1, 2'd0, 8'd150, 8'd150, 1'b0};
    v[1]  = '{8'h55, 1'b0, 2'd0, 8'd150, 8'd150, 1'b1};
    v[2]  = '{8'h0C, 1'b1, 2'd2, 8'd150, 8'd150, 1'b0};
    v[3]  = '{8'h03, 1'b0, 2'd0, 8'd150, 8'd150, 1'b0};
    v[4]  = '{8'h40, 1'b0, 2'd0, 8'd150, 8'd150, 1'b0};
    v[5]  = '{8'hC8, 1'b1, 2'd1, 8'h40,  8'hC8,  1'b0};
    v[6]  = '{8'h00, 1'b1, 2'd0, 8'h40,  8'hC8,  1'b0};
    v[7]  = '{8'hFF, 1'b0, 2'd0, 8'h40,  8'hC8,  1'b1};
    v[8]  = '{8'h03, 1'b0, 2'd0, 8'h40,  8'hC8,  1'b0};
    v[9]  = '{8'h05, 1'b0, 2'd0, 8'h40,  8'hC8,  1'b0};
    v[10] = '{8'hFF, 1'b1, 2'd1, CX,     CY,     1'b0};
    v[11] = '{8'h0C, 1'b1, 2'd2, CX,     CY,     1'b0};

    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_type", cmd_type, 0);
    chk("rst_x", servo_x, 150);
    chk("rst_y", servo_y, 150);
    chk("rst_err", {err_unknown, err_timeout, err_overrun}, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(v[i].b);
      chk($sformatf("v%0d_valid", i), cmd_valid, v[i].ev);
      if (v[i].ev)
        chk($sformatf("v%0d_type", i), cmd_type, v[i].et);
      chk($sformatf("v%0d_x", i), servo_x, v[i].ex);
      chk($sformatf("v%0d_y", i), servo_y, v[i].ey);
      chk($sformatf("v%0d_unk", i), err_unknown, v[i].eu);
      chk($sformatf("v%0d_ovr", i), err_overrun, 0);
      @(negedge clk);
      chk($sformatf("v%0d_drop", i), cmd_valid, 0);
    end

    // Overrun: TRIG held, INIT dropped.
    cmd_ready = 1'b0;
    send(8'h0C);
    chk("ovr_hold_v", cmd_valid, 1);
    repeat (10) @(negedge clk);
    chk("ovr_hold_v10", cmd_valid, 1);
    send(8'h00);
    chk("ovr_pulse", err_overrun, 1);
    chk("ovr_keep_v", cmd_valid, 1);
    chk("ovr_keep_t", cmd_type, 2);
    @(negedge clk);
    chk("ovr_pulse_end", err_overrun, 0);
    cmd_ready = 1'b1;
    #1;
    chk("ovr_pres_v", cmd_valid, 1);
    chk("ovr_pres_t", cmd_type, 2);
    @(negedge clk);
    chk("ovr_xfer", cmd_valid, 0);

    // Completion coincides with a transfer.
    cmd_ready = 1'b0;
    send(8'h0C);
    chk("same_v0", cmd_valid, 1);
    @(negedge clk);
    cmd_ready = 1'b1;
    send(8'h00);
    chk("same_v1", cmd_valid, 1);
    chk("same_t", cmd_type, 0);
    chk("same_ovr", err_overrun, 0);
    @(negedge clk);
    chk("same_done", cmd_valid, 0);

    // Reset mid-frame with a held command.
    cmd_ready = 1'b0;
    send(8'h0C);
    send(8'h03);
    send(8'h11);
    rst_i = 1'b1;
    #1;
    chk("mrst_valid", cmd_valid, 0);
    chk("mrst_type", cmd_type, 0);
    chk("mrst_x", servo_x, 150);
    chk("mrst_y", servo_y, 150);
    @(negedge clk);
    rst_i     = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    send(8'h00);
    chk("mrst_init_v", cmd_valid, 1);
    chk("mrst_init_t", cmd_type, 0);
    chk("mrst_init_y", servo_y, 150);
    @(negedge clk);

    // Inter-byte timeout.
    send(8'h03);
    send(8'h20);
    first = -1;
    for (int i = 1; i <= 3 * TO; i++) begin
      @(negedge clk);
      if (err_timeout && first < 0) first = i;
      if (first >= 0) break;
    end
    chk("tmo_latency", first, TO);
    @(negedge clk);
    chk("tmo_pulse_end", err_timeout, 0);
    send(8'h0C);
    chk("tmo_trig_v", cmd_valid, 1);
    chk("tmo_trig_t", cmd_type, 2);
    chk("tmo_x", servo_x, 150);
    chk("tmo_y", servo_y, 150);
    @(negedge clk);

    // rx_done lands in the expiry cycle and wins.
    seen = 1'b0;
    send(8'h03);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      seen |= err_timeout;
    end
    send(8'h77);
    seen |= err_timeout;
    send(8'h88);
    seen |= err_timeout;
    chk("race_v", cmd_valid, 1);
    chk("race_t", cmd_type, 1);
    chk("race_x", servo_x, 8'h77);
    chk("race_y", servo_y, 8'h88);
    repeat (TO + 2) begin
      @(negedge clk);
      seen |= err_timeout;
    end
    chk("race_no_tmo", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
